keypad_scan_fifo: RTL and testbench
===================================

// Module: keypad_scan_fifo
// PURPOSE
//  Parametrised ROWS x COLS matrix keypad scanner: column drive, row sampling, press/release debounce,
//  optional auto-repeat. Buffers key events in a FIFO with a valid/ready pop interface.
//  Sits between the keypad pins and the calculator datapath; replaces the fixed 4x4 single-event scanner.
// PARAMETERS
//  ROWS          4       number of row inputs (>=1)
//  COLS          4       number of column outputs (>=2)
//  SCAN_DIV      1000    clk cycles each column is driven before rows are sampled (>=3)
//  DEB_CYCLES    100000  consecutive stable clk cycles required to accept a press or a release
//  FIFO_DEPTH    8       key-event FIFO entries; must be a power of 2 (>=2)
//  REPEAT_EN     0       1 = emit repeat events while a key is held
//  REPEAT_DELAY  5000000 held cycles from the press event to the first repeat event
//  REPEAT_RATE   1000000 cycles between subsequent repeat events
//  CODE_W        localparam = $clog2(ROWS*COLS)
// PORTS
//  clk        in   1       system clock; the only clock
//  rst        in   1       synchronous reset, active-low
//  row        in   ROWS    keypad rows, active-low (pulled up), asynchronous
//  col        out  COLS    column drive, one-hot-low; registered
//  key_valid  out  1       FIFO non-empty; key_code is valid
//  key_code   out  CODE_W  head event: row_idx*COLS + col_idx
//  key_ready  in   1       consumer accepts head this cycle
//  key_down   out  1       debounced key currently held (S_HOLD or S_DEB_R)
//  overflow   out  1       sticky; an event was dropped because the FIFO was full
//  clr_ovf    in   1       one-cycle pulse clears overflow
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): col = ~1 (col[0] low), all counters 0, FSM = S_SCAN, FIFO empty,
//   key_valid = 0, key_code = 0, key_down = 0, overflow = 0, row synchroniser = all ones.
//  row passes a 2-flop synchroniser (rs); all decisions use rs. Added latency: 2 cycles.
//  FSM:
//   S_SCAN : div counts 0..SCAN_DIV-1 on the current column. At div==SCAN_DIV-1: if rs != all ones,
//            latch ci = current column and ri = lowest-index low row, clear deb, go to S_DEB_P;
//            else advance the column (COLS-1 wraps to 0) and clear div.
//   S_DEB_P: column held. rs[ri]==0 -> deb++. On deb==DEB_CYCLES-1, push {ri,ci} and go to S_HOLD.
//            rs[ri]==1 at any cycle -> S_SCAN; advance the column; no event (bounce rejected).
//   S_HOLD : key_down = 1. REPEAT_EN=1: rep counts; push at rep==REPEAT_DELAY-1, then every REPEAT_RATE
//            cycles. rs[ri]==1 -> S_DEB_R, clear deb. rep is not cleared on entry to S_DEB_R.
//   S_DEB_R: rs[ri]==1 -> deb++. On deb==DEB_CYCLES-1, go to S_SCAN and advance the column.
//            rs[ri]==0 -> return to S_HOLD (release bounce). No repeat pushes in this state.
//  Other keys pressed while one key is held or debouncing are ignored. Only a single key is tracked;
//   there is no rollover.
//  FIFO: show-ahead, registered outputs. A push in cycle N makes key_valid=1 at N+1; there is no
//   same-cycle bypass. pop = key_valid & key_ready.
//   Push when full and no pop -> event dropped, overflow <= 1.
//   Push when full with a pop in the same cycle -> both happen; count unchanged; no overflow.
//   Push when empty -> accepted; key_valid rises the next cycle.
//  clr_ovf and a new overflow in the same cycle -> overflow stays 1 (set wins).
//  Reset mid-operation (any state) -> all reset values above; pending FIFO contents are discarded.
// STRUCTURE
//  Shared include keypad_defs.vh: FSM state encodings S_SCAN/S_DEB_P/S_HOLD/S_DEB_R, CODE_W function.
//  Sub-module key_fifo (params WIDTH, DEPTH): synchronous FIFO, clk/rst, push/din, pop/dout,
//   full/empty. Scanner FSM, counters and synchroniser stay in keypad_scan_fifo.
// TESTING (bench: SCAN_DIV=4, DEB_CYCLES=8, FIFO_DEPTH=4, key model drives row from col)
//  1 Reset: rst=0 for 3 clks -> col=4'b1110, key_valid=0, key_code=0, overflow=0, key_down=0.
//  2 Press row2/col1 held 40 clks, key_ready=1 -> exactly one event, key_code=9 (4'b1001); key_down=1 while held.
//  3 row2/col1 low for 5 clks, then high -> no event; scanning resumes; col keeps rotating 1110->1101->1011->0111.
//  4 key_ready=0; 5 distinct presses (codes 0,5,10,15,3) -> FIFO holds 0,5,10,15; overflow=1; 3 lost;
//    clr_ovf -> overflow=0.
//  5 REPEAT_EN=1, REPEAT_DELAY=20, REPEAT_RATE=10; hold code 6 for 60 cycles after the press event
//    -> events at +0, +20, +30, +40, +50.
//  6 Rows 1 and 3 low on col 2 -> code 6 (lowest row wins); rst=0 during S_DEB_P -> no event, reset values.

Source files
------------

// File: rtl/keypad_scan_fifo_pkg.sv
// Shared types and helpers for the keypad scanner and its event FIFO.
package keypad_scan_fifo_pkg;

  // Scanner FSM states
  typedef enum logic [1:0] {
    StScan,
    StDebP,
    StHold,
    StDebR
  } kp_state_e;

  // Counter/index width that never collapses to zero bits
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/keypad_scan_fifo_fifo.sv
// Show-ahead synchronous FIFO with registered storage and occupancy.
module key_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
  assign dout_o  = mem_q[rd_q];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner with press/release debounce, optional auto-repeat and an event FIFO.
module keypad_scan_fifo
  import keypad_scan_fifo_pkg::*;
#(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEB_CYCLES   = 100000,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned REPEAT_EN    = 0,
  parameter int unsigned REPEAT_DELAY = 5000000,
  parameter int unsigned REPEAT_RATE  = 1000000,
  localparam int unsigned CODE_W      = clog2_min1(ROWS * COLS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ROWS-1:0]   row_i,
  output logic [COLS-1:0]   col_o,
  output logic              key_valid_o,
  output logic [CODE_W-1:0] key_code_o,
  input  logic              key_ready_i,
  output logic              key_down_o,
  output logic              overflow_o,
  input  logic              clr_ovf_i
);

  localparam int unsigned RowW   = clog2_min1(ROWS);
  localparam int unsigned ColW   = clog2_min1(COLS);
  localparam int unsigned DivW   = clog2_min1(SCAN_DIV);
  localparam int unsigned DebW   = clog2_min1(DEB_CYCLES);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = clog2_min1(RepMax);

  localparam logic [COLS-1:0] ColOne = {{(COLS - 1){1'b0}}, 1'b1};

  kp_state_e         state_q;
  logic [ROWS-1:0]   rs1_q;
  logic [ROWS-1:0]   rs_q;
  logic [DivW-1:0]   div_q;
  logic [DebW-1:0]   deb_q;
  logic [RepW-1:0]   rep_q;
  logic              rep_arm_q;
  logic [ColW-1:0]   cidx_q;
  logic [COLS-1:0]   col_q;
  logic [RowW-1:0]   ri_q;
  logic [ColW-1:0]   ci_q;
  logic              key_down_q;
  logic              push_q;
  logic [CODE_W-1:0] code_q;
  logic              ovf_q;

  logic [RowW-1:0]   low_idx;
  logic [ColW-1:0]   nxt_col;
  logic [CODE_W-1:0] cur_code;
  logic              row_hi;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign nxt_col  = (cidx_q == ColW'(COLS - 1)) ? '0 : cidx_q + 1'b1;
  assign cur_code = CODE_W'(int'(ri_q) * int'(COLS) + int'(ci_q));
  assign row_hi   = rs_q[ri_q];

  // Lowest-index row that reads low wins
  always_comb begin
    low_idx = '0;
    for (int i = int'(ROWS) - 1; i >= 0; i--) begin
      if (!rs_q[i]) low_idx = RowW'(i);
    end
  end

  // Two-flop synchroniser for the asynchronous row inputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rs1_q <= '1;
      rs_q  <= '1;
    end else begin
      rs1_q <= row_i;
      rs_q  <= rs1_q;
    end
  end

  // Scanner FSM with its counters and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StScan;
      div_q      <= '0;
      deb_q      <= '0;
      rep_q      <= '0;
      rep_arm_q  <= 1'b0;
      cidx_q     <= '0;
      col_q      <= ~ColOne;
      ri_q       <= '0;
      ci_q       <= '0;
      key_down_q <= 1'b0;
      push_q     <= 1'b0;
      code_q     <= '0;
    end else begin
      push_q <= 1'b0;
      unique case (state_q)
        StScan: begin
          if (div_q == DivW'(SCAN_DIV - 1)) begin
            div_q <= '0;
            if (rs_q != '1) begin
              ri_q    <= low_idx;
              ci_q    <= cidx_q;
              deb_q   <= '0;
              state_q <= StDebP;
            end else begin
              cidx_q <= nxt_col;
              col_q  <= ~(ColOne << nxt_col);
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        StDebP: begin
          if (!row_hi) begin
            if (deb_q == DebW'(DEB_CYCLES - 1)) begin
              push_q     <= 1'b1;
              code_q     <= cur_code;
              key_down_q <= 1'b1;
              rep_q      <= '0;
              rep_arm_q  <= 1'b0;
              state_q    <= StHold;
            end else begin
              deb_q <= deb_q + 1'b1;
            end
          end else begin
            // Bounce rejected: resume scanning on the next column
            state_q <= StScan;
            cidx_q  <= nxt_col;
            col_q   <= ~(ColOne << nxt_col);
          end
        end
        StHold: begin
          if (row_hi) begin
            deb_q   <= '0;
            state_q <= StDebR;
          end else if (REPEAT_EN != 0) begin
            // First repeat after the delay, then one every rate period
            if (rep_q == (rep_arm_q ? RepW'(REPEAT_RATE - 1) : RepW'(REPEAT_DELAY - 1))) begin
              push_q    <= 1'b1;
              code_q    <= cur_code;
              rep_q     <= '0;
              rep_arm_q <= 1'b1;
            end else begin
              rep_q <= rep_q + 1'b1;
            end
          end
        end
        StDebR: begin
          if (row_hi) begin
            if (deb_q == DebW'(DEB_CYCLES - 1)) begin
              key_down_q <= 1'b0;
              state_q    <= StScan;
              cidx_q     <= nxt_col;
              col_q      <= ~(ColOne << nxt_col);
            end else begin
              deb_q <= deb_q + 1'b1;
            end
          end else begin
            // Release bounce: the key is still held, repeat timing resumes where it left off
            state_q <= StHold;
          end
        end
        default: state_q <= StScan;
      endcase
    end
  end

  assign pop = ~fifo_empty & key_ready_i;

  // Sticky overflow: a drop sets it, and a set beats a simultaneous clear
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (push_q && fifo_full && !pop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf_i) begin
      ovf_q <= 1'b0;
    end
  end

  key_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_q),
    .din_i   (code_q),
    .pop_i   (pop),
    .dout_o  (key_code_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign col_o       = col_q;
  assign key_valid_o = ~fifo_empty;
  assign key_down_o  = key_down_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: a key-matrix model drives rows from the column outputs.
module tb_keypad_scan_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] press_a, press_b;
  logic [3:0]  row_a, row_b, col_a, col_b;
  logic        valid_a, valid_b, ready_a, ready_b;
  logic [3:0]  code_a, code_b;
  logic        down_a, down_b, ovf_a, ovf_b, clr_a, clr_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ev_a = 0;
  logic [3:0] last_a = '0;
  int ts_b[$];
  logic [3:0] codes_b[$];

  typedef struct {
    logic [15:0] mask;
    int          hold;
    int          exp_n;
    logic [3:0]  code;
  } vec_t;
  vec_t vecs[5];

  // Key matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row_a = '1;
    row_b = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (press_a[r*4+c] && !col_a[c]) row_a[r] = 1'b0;
        if (press_b[r*4+c] && !col_b[c]) row_b[r] = 1'b0;
      end
    end
  end

  keypad_scan_fifo #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEB_CYCLES(8), .FIFO_DEPTH(4),
    .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_RATE(10)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .row_i(row_a), .col_o(col_a),
    .key_valid_o(valid_a), .key_code_o(code_a), .key_ready_i(ready_a),
    .key_down_o(down_a), .overflow_o(ovf_a), .clr_ovf_i(clr_a)
  );

  keypad_scan_fifo #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEB_CYCLES(8), .FIFO_DEPTH(4),
    .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_RATE(10)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .row_i(row_b), .col_o(col_b),
    .key_valid_o(valid_b), .key_code_o(code_b), .key_ready_i(ready_b),
    .key_down_o(down_b), .overflow_o(ovf_b), .clr_ovf_i(clr_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: every accepted head is one event
  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      ev_a   = ev_a + 1;
      last_a = code_a;
    end
    if (valid_b && ready_b) begin
      ts_b.push_back(cyc);
      codes_b.push_back(code_b);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " col"}, 32'(col_a), 32'h0000_000e);
    chk({tag, " key_valid"}, 32'(valid_a), 0);
    chk({tag, " key_code"}, 32'(code_a), 0);
    chk({tag, " overflow"}, 32'(ovf_a), 0);
    chk({tag, " key_down"}, 32'(down_a), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] prev;
    int first;
    int waited;
    int seq[5];

    vecs[0] = '{16'h0200, 40, 1, 4'd9};   // row2/col1 held
    vecs[1] = '{16'h0200, 5,  0, 4'd0};   // short bounce
    vecs[2] = '{16'h4040, 40, 1, 4'd6};   // rows 1 and 3 on col2
    vecs[3] = '{16'h0001, 40, 1, 4'd0};
    vecs[4] = '{16'h8000, 40, 1, 4'd15};
    seq = '{0, 5, 10, 15, 3};

    rst_n = 1'b0; press_a = '0; press_b = '0;
    ready_a = 1'b1; ready_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    step(3);
    @(negedge clk);
    chk_reset_vals("reset");

    // Exact latency with key 0 held out of reset
    step(1);
    press_a = 16'h0001;
    step(1);
    rst_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 11) chk("key_down before press accepted", 32'(down_a), 0);
      if (n == 12) chk("key_down on press accepted", 32'(down_a), 1);
      if (valid_a && first == 0) first = n;
    end
    chk("first key_valid cycle", first, 13);
    step(1);
    press_a = '0;
    step(40);
    chk("latency run event count", ev_a, 1);
    chk("latency run code", 32'(last_a), 0);

    // Reset while debouncing a press
    rst_n = 1'b0; press_a = 16'h0001; ev_a = 0;
    step(2);
    rst_n = 1'b1;
    step(8);
    rst_n = 1'b0;
    step(2);
    @(negedge clk);
    chk_reset_vals("mid-debounce reset");
    step(1);
    press_a = '0;
    rst_n = 1'b1;
    step(40);
    chk("no event after mid-debounce reset", ev_a, 0);

    // Table of single presses
    for (int i = 0; i < 5; i++) begin
      ev_a = 0;
      press_a = vecs[i].mask;
      step(vecs[i].hold - 2);
      @(negedge clk);
      chk($sformatf("vec%0d key_down while held", i), 32'(down_a), 32'(vecs[i].exp_n != 0));
      step(2);
      press_a = '0;
      step(40);
      @(negedge clk);
      chk($sformatf("vec%0d event count", i), ev_a, vecs[i].exp_n);
      if (vecs[i].exp_n != 0) chk($sformatf("vec%0d key_code", i), 32'(last_a), 32'(vecs[i].code));
      chk($sformatf("vec%0d key_down after release", i), 32'(down_a), 0);
    end

    // Column keeps rotating one-hot-low
    for (int k = 0; k < 4; k++) begin
      prev = col_a;
      waited = 0;
      while (col_a == prev && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      chk($sformatf("col rotate %0d", k), 32'(col_a), 32'({prev[2:0], prev[3]}));
    end

    // FIFO fill and overflow with the consumer stalled
    step(1);
    ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      press_a = 16'(1) << seq[i];
      step(40);
      press_a = '0;
      step(40);
    end
    @(negedge clk);
    chk("overflow after 5 events", 32'(ovf_a), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("fifo entry %0d valid", i), 32'(valid_a), 1);
      chk($sformatf("fifo entry %0d code", i), 32'(code_a), 32'(seq[i]));
      #1 ready_a = 1'b1;
      @(posedge clk);
      #1 ready_a = 1'b0;
    end
    @(negedge clk);
    chk("fifo empty after 4 pops", 32'(valid_a), 0);
    chk("overflow still sticky", 32'(ovf_a), 1);
    step(1);
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    @(negedge clk);
    chk("overflow cleared", 32'(ovf_a), 0);
    step(1);
    ready_a = 1'b1;

    // Auto-repeat on the second instance
    ts_b.delete();
    codes_b.delete();
    press_b = 16'(1) << 6;
    waited = 0;
    while (ts_b.size() == 0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    chk("repeat press event seen", 32'(ts_b.size() != 0), 1);
    step(52);
    press_b = '0;
    step(40);
    chk("repeat event count", ts_b.size(), 5);
    if (ts_b.size() == 5) begin
      for (int i = 1; i < 5; i++) begin
        chk($sformatf("repeat gap %0d", i), ts_b[i] - ts_b[i-1], (i == 1) ? 20 : 10);
      end
      for (int i = 0; i < 5; i++) chk($sformatf("repeat code %0d", i), 32'(codes_b[i]), 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
